apb_xfer_sched: RTL and testbench

//  Schedules decoded bridge commands onto the four APB master ports of the crypto bridge.

---
 rtl/apb_xfer_sched.sv | 170 +++++++++++++++++
 tb/tb_apb_xfer_sched.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_xfer_sched.sv
// Command-to-APB scheduler: four independent SETUP/ACCESS sequencers with a round-robin response arbiter.
// Optional ACCESS-phase timeout is compiled in when the APB_TIMEOUT_EN macro is defined.
module apb_xfer_sched #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [1:0]          cmd_port,
    input  logic                cmd_write,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [DATA_W-1:0]   cmd_wdata,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [1:0]          rsp_port,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,
    output logic [3:0]          psel,
    output logic [3:0]          penable,
    output logic [3:0]          pwrite,
    output logic [4*ADDR_W-1:0] paddr,
    output logic [4*DATA_W-1:0] pwdata,
    input  logic [4*DATA_W-1:0] prdata,
    input  logic [3:0]          pready,
    input  logic [3:0]          pslverr
);
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} st_e;

    if (TIMEOUT_CYC < 1) begin : g_cfg_check
        $error("TIMEOUT_CYC must be at least 1");
    end

    st_e                 state_q [4];
    logic [DATA_W-1:0]   slot_rdata_q [4];
    logic [3:0]          slot_err_q;
    logic [3:0]          psel_q, penable_q, pwrite_q;
    logic [4*ADDR_W-1:0] paddr_q;
    logic [4*DATA_W-1:0] pwdata_q;
    logic                rsp_valid_q, rsp_err_q;
    logic [1:0]          rsp_port_q, rr_ptr_q;
    logic [DATA_W-1:0]   rsp_rdata_q;

    logic                accept, pop;
    logic [3:0]          tmo, fin, elig, cmp_err;
    logic [DATA_W-1:0]   cmp_rdata [4];
    logic                gnt_found, gnt_err;
    logic [1:0]          gnt_idx, scan;
    logic [DATA_W-1:0]   gnt_rdata;

    assign cmd_ready = (state_q[cmd_port] == IDLE);
    assign accept    = cmd_valid && cmd_ready;
    assign pop       = rsp_valid_q && rsp_ready;

`ifdef APB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] cnt_q [4];

    always_ff @(posedge clk) begin
        for (int n = 0; n < 4; n++) begin
            if (rst || state_q[n] == SETUP) begin
                cnt_q[n] <= '0;
            end else if (state_q[n] == ACCESS && !pready[n]) begin
                cnt_q[n] <= cnt_q[n] + CNT_W'(1);
            end
        end
    end

    // The cycle that would bring the count to TIMEOUT_CYC is the last ACCESS cycle.
    always_comb begin
        for (int n = 0; n < 4; n++) begin
            tmo[n] = (state_q[n] == ACCESS) && !pready[n] &&
                     (cnt_q[n] == CNT_W'(TIMEOUT_CYC - 1));
        end
    end
`else
    assign tmo = '0;
`endif

    always_comb begin
        for (int n = 0; n < 4; n++) begin
            fin[n]       = (state_q[n] == ACCESS) && (pready[n] || tmo[n]);
            elig[n]      = (state_q[n] == DONE) || fin[n];
            cmp_err[n]   = tmo[n] || pslverr[n];
            cmp_rdata[n] = (pwrite_q[n] || tmo[n]) ? '0 : prdata[n*DATA_W +: DATA_W];
        end
    end

    // Completing ports are eligible in the same cycle so a response appears one cycle after pready.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = rr_ptr_q;
        scan      = rr_ptr_q;
        for (int k = 0; k < 4; k++) begin
            scan = rr_ptr_q + 2'(k);
            if (!gnt_found && elig[scan]) begin
                gnt_found = 1'b1;
                gnt_idx   = scan;
            end
        end
        gnt_rdata = (state_q[gnt_idx] == DONE) ? slot_rdata_q[gnt_idx] : cmp_rdata[gnt_idx];
        gnt_err   = (state_q[gnt_idx] == DONE) ? slot_err_q[gnt_idx]   : cmp_err[gnt_idx];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int n = 0; n < 4; n++) begin
                state_q[n] <= IDLE;
            end
            psel_q      <= '0;
            penable_q   <= '0;
            pwrite_q    <= '0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_port_q  <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            rr_ptr_q    <= '0;
        end else begin
            for (int n = 0; n < 4; n++) begin
                case (state_q[n])
                    IDLE: if (accept && cmd_port == 2'(n)) begin
                        state_q[n]                   <= SETUP;
                        psel_q[n]                    <= 1'b1;
                        pwrite_q[n]                  <= cmd_write;
                        paddr_q[n*ADDR_W +: ADDR_W]  <= cmd_addr;
                        pwdata_q[n*DATA_W +: DATA_W] <= cmd_wdata;
                    end
                    SETUP: begin
                        state_q[n]   <= ACCESS;
                        penable_q[n] <= 1'b1;
                    end
                    ACCESS: if (fin[n]) begin
                        state_q[n]      <= DONE;
                        psel_q[n]       <= 1'b0;
                        penable_q[n]    <= 1'b0;
                        slot_rdata_q[n] <= cmp_rdata[n];
                        slot_err_q[n]   <= cmp_err[n];
                    end
                    default: if (pop && rsp_port_q == 2'(n)) begin
                        state_q[n] <= IDLE;
                    end
                endcase
            end
            // A pop leaves one idle cycle before the next grant is presented.
            if (pop) begin
                rsp_valid_q <= 1'b0;
                rr_ptr_q    <= rsp_port_q + 2'd1;
            end else if (!rsp_valid_q && gnt_found) begin
                rsp_valid_q <= 1'b1;
                rsp_port_q  <= gnt_idx;
                rsp_rdata_q <= gnt_rdata;
                rsp_err_q   <= gnt_err;
            end
        end
    end

    assign psel      = psel_q;
    assign penable   = penable_q;
    assign pwrite    = pwrite_q;
    assign paddr     = paddr_q;
    assign pwdata    = pwdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_port  = rsp_port_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_apb_xfer_sched.sv
// Bench for apb_xfer_sched: single-transfer vector table, multi-cycle corner sequences, random traffic.
module tb_apb_xfer_sched;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int TMO = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [1:0]    cmd_port;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          rsp_valid, rsp_ready, rsp_err;
    logic [1:0]    rsp_port;
    logic [DW-1:0] rsp_rdata;
    logic [3:0]    psel, penable, pwrite, pready, pslverr;
    logic [4*AW-1:0] paddr;
    logic [4*DW-1:0] pwdata, prdata;

    apb_xfer_sched #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_port(cmd_port),
        .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_port(rsp_port),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
        .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  port;
        logic        write;
        logic [31:0] addr, wdata, prdata;
        int          waits;
        logic        slverr;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic        write;
        logic [31:0] addr, wdata, rdata;
        logic        err;
    } exp_t;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   slave_mode = 0;   // 0 mask-driven, 1 ports 1/3 together, 2 manual, 3 random slave
    logic [3:0] mask = 4'h0;
    int   wcnt [4];
    exp_t expq [4][$];
    logic [3:0] busy = 4'h0;
    int   n_acc = 0;
    int   n_rsp = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        case (slave_mode)
            0, 1: begin
                pslverr = '0;
                for (int n = 0; n < 4; n++) prdata[n*DW +: DW] = {16'hC0DE, 16'(n)};
                if (slave_mode == 0) pready = psel & penable & mask;
                else pready = (psel[1] && penable[1] && psel[3] && penable[3]) ? 4'b1010 : 4'b0000;
            end
            3: begin
                for (int n = 0; n < 4; n++) begin
                    pready[n]  = 1'b0;
                    pslverr[n] = 1'b0;
                    if (psel[n] && !penable[n]) begin
                        wcnt[n] = $urandom_range(0, 3);
                    end else if (psel[n] && penable[n]) begin
                        if (wcnt[n] == 0) begin
                            pready[n] = 1'b1;
                            prdata[n*DW +: DW] = paddr[n*AW +: AW] ^ 32'h5A5A_0000 ^ 32'(n);
                            pslverr[n] = paddr[n*AW + 3];
                        end else begin
                            wcnt[n]--;
                        end
                    end
                end
            end
            default: ;
        endcase
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic issue(input logic [1:0] p, input logic w, input logic [31:0] a, input logic [31:0] d);
        cmd_valid = 1'b1;
        cmd_port  = p;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
    endtask

    task automatic pop_rsp();
        tick(); rsp_ready = 1'b1; cmd_valid = 1'b0; sample();
        tick(); rsp_ready = 1'b0; sample();
        chk("pop_clears_valid", rsp_valid, 1'b0);
    endtask

    task automatic run_vec(input vec_t v, input string nm);
        int nsel, nen, acc, lat;
        bit got;
        nsel = 0; nen = 0; acc = 0; got = 1'b0; lat = 0;
        slave_mode = 2;
        tick(); issue(v.port, v.write, v.addr, v.wdata); rsp_ready = 1'b0; pready = '0; sample();
        chk({nm, "_cmd_ready"}, cmd_ready, 1'b1);
        tick(); cmd_valid = 1'b0;
        for (lat = 1; lat < 40; lat++) begin
            pready = '0;
            pslverr = '0;
            if (psel[v.port] && penable[v.port] && acc == v.waits) begin
                pready[v.port]  = 1'b1;
                pslverr[v.port] = v.slverr;
                prdata[v.port*DW +: DW] = v.prdata;
            end
            sample();
            if (psel[v.port] && !penable[v.port]) begin
                chk({nm, "_paddr"}, paddr[v.port*AW +: AW], v.addr);
                chk({nm, "_pwrite"}, pwrite[v.port], v.write);
                if (v.write) chk({nm, "_pwdata"}, pwdata[v.port*DW +: DW], v.wdata);
            end
            if (psel[v.port]) nsel++;
            if (penable[v.port]) begin nen++; acc++; end
            if (rsp_valid) begin got = 1'b1; break; end
            tick();
        end
        chk({nm, "_rsp_seen"}, got, 1'b1);
        if (got) begin
            chk({nm, "_latency"}, lat, v.waits + 3);
            chk({nm, "_port"}, rsp_port, v.port);
            chk({nm, "_rdata"}, rsp_rdata, v.exp_rdata);
            chk({nm, "_err"}, rsp_err, v.exp_err);
            chk({nm, "_psel_cycles"}, nsel, v.waits + 2);
            chk({nm, "_penable_cycles"}, nen, v.waits + 1);
            pop_rsp();
            chk({nm, "_ready_after_pop"}, cmd_ready, 1'b1);
        end
    endtask

    task automatic rnd_check();
        exp_t e;
        for (int n = 0; n < 4; n++) begin
            if (pready[n]) begin
                chk("rnd_inflight_known", expq[n].size() > 0, 1'b1);
                if (expq[n].size() > 0) begin
                    chk("rnd_paddr", paddr[n*AW +: AW], expq[n][0].addr);
                    chk("rnd_pwrite", pwrite[n], expq[n][0].write);
                    if (expq[n][0].write) chk("rnd_pwdata", pwdata[n*DW +: DW], expq[n][0].wdata);
                end
            end
        end
        if (cmd_valid) begin
            chk("rnd_cmd_ready", cmd_ready, !busy[cmd_port]);
            if (cmd_ready) begin
                e.write = cmd_write;
                e.addr  = cmd_addr;
                e.wdata = cmd_wdata;
                e.rdata = cmd_write ? 32'h0 : (cmd_addr ^ 32'h5A5A_0000 ^ 32'(cmd_port));
                e.err   = cmd_addr[3];
                expq[cmd_port].push_back(e);
                busy[cmd_port] = 1'b1;
                n_acc++;
            end
        end
        if (rsp_valid && rsp_ready) begin
            chk("rnd_rsp_expected", expq[rsp_port].size() > 0, 1'b1);
            if (expq[rsp_port].size() > 0) begin
                e = expq[rsp_port].pop_front();
                chk("rnd_rdata", rsp_rdata, e.rdata);
                chk("rnd_err", rsp_err, e.err);
            end
            busy[rsp_port] = 1'b0;
            n_rsp++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vecs [6];
        int   ord [$];
        int   exp_ord [5] = '{0, 1, 2, 3, 0};
        int   vcnt, nacc;
        bit   got;

        vecs[0] = '{2'd2, 1'b0, 32'h0000_0010, 32'h0, 32'hA5A5_0001, 0, 1'b0, 32'hA5A5_0001, 1'b0};
        vecs[1] = '{2'd1, 1'b1, 32'h0000_2000, 32'h1234_5678, 32'hDEAD_BEEF, 7, 1'b1, 32'h0, 1'b1};
        vecs[2] = '{2'd0, 1'b0, 32'h0000_0004, 32'h0, 32'h0000_FFFF, 2, 1'b1, 32'h0000_FFFF, 1'b1};
        vecs[3] = '{2'd3, 1'b1, 32'h0000_0008, 32'hCAFE_F00D, 32'h1111_1111, 0, 1'b0, 32'h0, 1'b0};
        vecs[4] = '{2'd3, 1'b0, 32'hFFFF_FFFC, 32'h0, 32'hFFFF_FFFF, 1, 1'b0, 32'hFFFF_FFFF, 1'b0};
        vecs[5] = '{2'd0, 1'b1, 32'h8000_0000, 32'h0BAD_F00D, 32'h7777_7777, 3, 1'b0, 32'h0, 1'b0};

        rst = 1'b1; cmd_valid = 1'b0; cmd_port = '0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        rsp_ready = 1'b0; pready = '0; pslverr = '0; prdata = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        sample();
        chk("reset_rsp_valid", rsp_valid, 1'b0);
        chk("reset_rsp_port", rsp_port, 2'd0);
        chk("reset_rsp_rdata", rsp_rdata, 32'h0);
        chk("reset_rsp_err", rsp_err, 1'b0);
        chk("reset_psel", psel, 4'h0);
        chk("reset_penable", penable, 4'h0);
        chk("reset_pwrite", pwrite, 4'h0);
        chk("reset_paddr", paddr[63:0] | paddr[127:64], 64'h0);
        chk("reset_pwdata", pwdata[63:0] | pwdata[127:64], 64'h0);
        chk("reset_cmd_ready", cmd_ready, 1'b1);

        for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Four back-to-back writes, then port 0 again right after its pop
        slave_mode = 0; mask = 4'hF; rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick(); issue(2'(i), 1'b1, 32'(i * 4), 32'h100 + 32'(i)); sample();
            chk("bb_cmd_ready", cmd_ready, 1'b1);
            if (rsp_valid && rsp_ready) ord.push_back(int'(rsp_port));
        end
        chk("bb_first_rsp_valid", rsp_valid, 1'b1);
        chk("bb_first_rsp_port", rsp_port, 2'd0);
        tick(); issue(2'd0, 1'b1, 32'h40, 32'h200); sample();
        chk("bb_reaccept_port0", cmd_ready, 1'b1);
        if (rsp_valid && rsp_ready) ord.push_back(int'(rsp_port));
        for (int c = 0; c < 40 && ord.size() < 5; c++) begin
            tick(); cmd_valid = 1'b0; sample();
            if (rsp_valid && rsp_ready) ord.push_back(int'(rsp_port));
        end
        chk("bb_rsp_count", ord.size(), 5);
        for (int i = 0; i < 5; i++)
            if (i < ord.size()) chk($sformatf("bb_order%0d", i), ord[i], exp_ord[i]);
        tick(); rsp_ready = 1'b0; cmd_valid = 1'b0; sample();

        // Ports 1 and 3 complete together with the pointer at 2
        run_vec('{2'd1, 1'b0, 32'h30, 32'h0, 32'h1, 0, 1'b0, 32'h1, 1'b0}, "rr_setup");
        slave_mode = 1; rsp_ready = 1'b0;
        tick(); issue(2'd1, 1'b0, 32'h50, 32'h0); sample(); chk("rr_cmd1", cmd_ready, 1'b1);
        tick(); issue(2'd3, 1'b0, 32'h54, 32'h0); sample(); chk("rr_cmd3", cmd_ready, 1'b1);
        got = 1'b0;
        for (int c = 0; c < 20; c++) begin
            tick(); cmd_valid = 1'b0; sample();
            if (rsp_valid) begin got = 1'b1; break; end
        end
        chk("rr_first_seen", got, 1'b1);
        for (int c = 0; c < 6; c++) begin
            chk("rr_hold_valid", rsp_valid, 1'b1);
            chk("rr_hold_port", rsp_port, 2'd3);
            chk("rr_hold_rdata", rsp_rdata, 32'hC0DE_0003);
            chk("rr_hold_err", rsp_err, 1'b0);
            if (c < 5) begin tick(); sample(); end
        end
        pop_rsp();
        got = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick(); sample();
            if (rsp_valid) begin got = 1'b1; break; end
        end
        chk("rr_second_seen", got, 1'b1);
        chk("rr_second_port", rsp_port, 2'd1);
        chk("rr_second_rdata", rsp_rdata, 32'hC0DE_0001);
        pop_rsp();

        // Reset while port 0 is waiting in ACCESS
        slave_mode = 0; mask = 4'h0;
        tick(); issue(2'd0, 1'b0, 32'h60, 32'h0); sample(); chk("rst_cmd", cmd_ready, 1'b1);
        tick(); cmd_valid = 1'b0; sample();
        tick(); sample();
        chk("rst_in_access", {psel[0], penable[0]}, 2'b11);
        tick(); rst = 1'b1; sample();
        tick(); rst = 1'b0; cmd_port = 2'd0; sample();
        chk("rst_psel", psel, 4'h0);
        chk("rst_penable", penable, 4'h0);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_cmd_ready", cmd_ready, 1'b1);
        mask = 4'hF; rsp_ready = 1'b1; vcnt = 0;
        for (int c = 0; c < 8; c++) begin
            tick(); sample();
            if (rsp_valid) vcnt++;
        end
        chk("rst_no_stale_rsp", vcnt, 0);
        rsp_ready = 1'b0;

        // ACCESS with pready held low
        mask = 4'h0;
        tick(); issue(2'd2, 1'b0, 32'h70, 32'h0); sample(); chk("tmo_cmd", cmd_ready, 1'b1);
        tick(); cmd_valid = 1'b0;
`ifdef APB_TIMEOUT_EN
        nacc = 0; got = 1'b0;
        for (int c = 0; c < 60; c++) begin
            sample();
            if (penable[2]) nacc++;
            if (rsp_valid) begin got = 1'b1; break; end
            tick();
        end
        chk("tmo_rsp_seen", got, 1'b1);
        chk("tmo_access_cycles", nacc, TMO);
        chk("tmo_port", rsp_port, 2'd2);
        chk("tmo_rdata", rsp_rdata, 32'h0);
        chk("tmo_err", rsp_err, 1'b1);
        chk("tmo_psel_dropped", psel[2], 1'b0);
        pop_rsp();
`else
        vcnt = 0; nacc = 0;
        for (int c = 1; c <= 100; c++) begin
            sample();
            if (rsp_valid) vcnt++;
            if (c < 100) tick();
        end
        chk("notmo_still_access", {psel[2], penable[2]}, 2'b11);
        chk("notmo_no_rsp", vcnt, 0);
        mask = 4'b0100; got = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick(); sample();
            if (rsp_valid) begin got = 1'b1; break; end
        end
        chk("notmo_rsp_seen", got, 1'b1);
        chk("notmo_rdata", rsp_rdata, 32'hC0DE_0002);
        chk("notmo_err", rsp_err, 1'b0);
        pop_rsp();
`endif

        // Random traffic against the per-port scoreboard
        slave_mode = 3; busy = 4'h0; n_acc = 0; n_rsp = 0;
        for (int n = 0; n < 4; n++) wcnt[n] = 0;
        for (int c = 0; c < 800; c++) begin
            tick();
            if ($urandom_range(0, 3) != 0)
                issue(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom, $urandom);
            else
                cmd_valid = 1'b0;
            rsp_ready = ($urandom_range(0, 2) != 0);
            sample();
            rnd_check();
        end
        for (int c = 0; c < 300; c++) begin
            tick(); cmd_valid = 1'b0; rsp_ready = 1'b1; sample();
            rnd_check();
            if (busy == 4'h0 && !rsp_valid) break;
        end
        chk("rnd_drained", expq[0].size() + expq[1].size() + expq[2].size() + expq[3].size(), 0);
        chk("rnd_rsp_count", n_rsp, n_acc);
        chk("rnd_traffic_seen", n_acc > 50, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
